// File: rtl/piece_pkg.sv
// Shared types for the piecewise scan read/write address generators.
// The state enum, the frame configuration bundle and the default address width.
package piece_pkg;

  localparam int PIECE_ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} piece_state_t;

  typedef struct packed {
    logic [PIECE_ADDR_W-1:0] x_max;
    logic [PIECE_ADDR_W-1:0] y_max;
    logic [PIECE_ADDR_W-1:0] i0_piece;
    logic [PIECE_ADDR_W-1:0] i1_piece;
    logic [PIECE_ADDR_W-1:0] x_stride_0;
    logic [PIECE_ADDR_W-1:0] x_stride_1;
    logic [PIECE_ADDR_W-1:0] y_stride_0;
    logic [PIECE_ADDR_W-1:0] y_stride_1;
    logic [PIECE_ADDR_W-1:0] offset_0;
    logic [PIECE_ADDR_W-1:0] offset_1;
    logic [PIECE_ADDR_W-1:0] offset_2;
    logic [PIECE_ADDR_W-1:0] offset_3;
  } piece_cfg_t;

endpackage

// File: rtl/piece_addr_calc.sv
// Four-quadrant affine address: x*xs + y*ys + off, wrapping at the address width.
// Shared by the read-side generator and the write port so both agree on layout.
module piece_addr_calc
  import piece_pkg::*;
(
  input  logic [PIECE_ADDR_W-1:0] x,
  input  logic [PIECE_ADDR_W-1:0] y,
  input  piece_cfg_t              cfg,
  output logic [PIECE_ADDR_W-1:0] addr
);

  logic                    x_hi;
  logic                    y_hi;
  logic [PIECE_ADDR_W-1:0] xs;
  logic [PIECE_ADDR_W-1:0] ys;
  logic [PIECE_ADDR_W-1:0] off;

  always_comb begin
    x_hi = (x >= cfg.i0_piece);
    y_hi = (y >= cfg.i1_piece);
    xs   = x_hi ? cfg.x_stride_1 : cfg.x_stride_0;
    ys   = y_hi ? cfg.y_stride_1 : cfg.y_stride_0;
    off  = cfg.offset_0;
    // Quadrant index puts the x split in the high bit.
    case ({x_hi, y_hi})
      2'b00:   off = cfg.offset_0;
      2'b01:   off = cfg.offset_1;
      2'b10:   off = cfg.offset_2;
      default: off = cfg.offset_3;
    endcase
    addr = x * xs + y * ys + off;
  end

endmodule

// File: rtl/piece_write_port.sv
// Pixel stream to memory write requests in the piecewise scan layout.
// One output register stage; in_ready follows the skid-free ready rule.
module piece_write_port
  import piece_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = PIECE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] x_max,
  input  logic [ADDR_W-1:0] y_max,
  input  logic [ADDR_W-1:0] i0_piece,
  input  logic [ADDR_W-1:0] i1_piece,
  input  logic [ADDR_W-1:0] x_stride_0,
  input  logic [ADDR_W-1:0] x_stride_1,
  input  logic [ADDR_W-1:0] y_stride_0,
  input  logic [ADDR_W-1:0] y_stride_1,
  input  logic [ADDR_W-1:0] offset_0,
  input  logic [ADDR_W-1:0] offset_1,
  input  logic [ADDR_W-1:0] offset_2,
  input  logic [ADDR_W-1:0] offset_3,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done
);

  piece_state_t      state_q, state_d;
  piece_cfg_t        cfg_in, cfg_q;
  logic [ADDR_W-1:0] x_q, y_q;
  logic [ADDR_W-1:0] addr_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic              accept, issue, x_last, y_last;

  assign cfg_in = '{x_max: x_max, y_max: y_max, i0_piece: i0_piece,
                    i1_piece: i1_piece, x_stride_0: x_stride_0,
                    x_stride_1: x_stride_1, y_stride_0: y_stride_0,
                    y_stride_1: y_stride_1, offset_0: offset_0,
                    offset_1: offset_1, offset_2: offset_2, offset_3: offset_3};

  assign in_ready   = (state_q == RUN) && (!vld_p1 || wr_ready);
  assign accept     = in_valid && in_ready;
  assign issue      = vld_p1 && wr_ready;
  assign x_last     = (x_q == cfg_q.x_max - ADDR_W'(1));
  assign y_last     = (y_q == cfg_q.y_max - ADDR_W'(1));
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);

  piece_addr_calc u_addr (
    .x    (x_q),
    .y    (y_q),
    .cfg  (cfg_q),
    .addr (addr_p0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (x_max == '0 || y_max == '0) ? DONE : RUN;
      RUN:   if (accept && x_last && y_last) state_d = DRAIN;
      DRAIN: if (issue) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: address/data captured into the write request register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cfg_q <= cfg_in;
        x_q   <= '0;
        y_q   <= '0;
      end
      if (accept) begin
        vld_p1  <= 1'b1;
        addr_p1 <= addr_p0;
        data_p1 <= in_data;
        if (x_last) begin
          x_q <= '0;
          y_q <= y_q + ADDR_W'(1);
        end else begin
          x_q <= x_q + ADDR_W'(1);
        end
      end else if (issue) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign wr_valid = vld_p1;
  assign wr_addr  = addr_p1;
  assign wr_data  = data_p1;

endmodule

// File: tb/tb_piece_write_port.sv
// Scoreboard bench for piece_write_port: expected writes queued on pixel accept,
// popped and compared when the port issues a write.
module tb_piece_write_port;
  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] x_max, y_max, i0_piece, i1_piece;
  logic [AW-1:0] x_stride_0, x_stride_1, y_stride_0, y_stride_1;
  logic [AW-1:0] offset_0, offset_1, offset_2, offset_3;
  logic          in_valid, in_ready, wr_valid, wr_ready, busy, frame_done;
  logic [DW-1:0] in_data, wr_data;
  logic [AW-1:0] wr_addr;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sb[$];
  logic [AW-1:0] exp_addr[16];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  always #5 clk = ~clk;

  piece_write_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .x_max(x_max), .y_max(y_max),
    .i0_piece(i0_piece), .i1_piece(i1_piece),
    .x_stride_0(x_stride_0), .x_stride_1(x_stride_1),
    .y_stride_0(y_stride_0), .y_stride_1(y_stride_1),
    .offset_0(offset_0), .offset_1(offset_1), .offset_2(offset_2), .offset_3(offset_3),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic set_cfg(input logic [AW-1:0] xm, ym, i0, i1, xs0, xs1, ys0, ys1,
                         o0, o1, o2, o3);
    x_max = xm; y_max = ym; i0_piece = i0; i1_piece = i1;
    x_stride_0 = xs0; x_stride_1 = xs1; y_stride_0 = ys0; y_stride_1 = ys1;
    offset_0 = o0; offset_1 = o1; offset_2 = o2; offset_3 = o3;
  endtask

  task automatic cfg_basic();
    set_cfg(16'd4, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd10, 16'd20,
            16'd0, 16'd100, 16'd200, 16'd300);
    exp_addr[0] = 16'd0;   exp_addr[1] = 16'd1;   exp_addr[2] = 16'd204;
    exp_addr[3] = 16'd206; exp_addr[4] = 16'd120; exp_addr[5] = 16'd121;
    exp_addr[6] = 16'd324; exp_addr[7] = 16'd326;
  endtask

  // Pulses start across one rising edge; returns at the following falling edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives npix pixels with wr_ready low for cycles stall_lo..stall_hi,
  // optionally pulsing start at cycle start_at; expects frame_done at cycle done_c.
  task automatic run_frame(input int npix, input int stall_lo, input int stall_hi,
                           input int done_c, input int start_at);
    int            sent = 0;
    bit            done = 0;
    bit            stalled_prev = 0;
    logic [AW-1:0] prev_addr = '0;
    wr_t           e;
    for (int c = 0; c < 200 && !done; c++) begin
      wr_ready = !(c >= stall_lo && c <= stall_hi);
      start    = (c == start_at);
      in_valid = (sent < npix);
      in_data  = 16'hA000 + 16'(sent);
      #1;
      if (c == 0) begin
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_run: got %b expected 1", busy);
        else pass_cnt++;
      end
      if (stalled_prev) begin
        total_cnt++;
        if (wr_addr !== prev_addr) $display("FAIL stall_hold: got %h expected %h", wr_addr, prev_addr);
        else pass_cnt++;
      end
      if (wr_valid && !wr_ready) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        else pass_cnt++;
        stalled_prev = 1;
        prev_addr    = wr_addr;
      end else begin
        stalled_prev = 0;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{a: exp_addr[sent], d: in_data});
        sent++;
      end
      if (wr_valid && wr_ready) begin
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL extra_write: got addr %h expected no write", wr_addr);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.a || wr_data !== e.d)
            $display("FAIL write: got %h/%h expected %h/%h", wr_addr, wr_data, e.a, e.d);
          else pass_cnt++;
        end
      end
      if (frame_done === 1'b1) begin
        done = 1;
        total_cnt++;
        if (c != done_c) $display("FAIL done_cycle: got %0d expected %0d", c, done_c);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    wr_ready = 1'b1;
    total_cnt++;
    if (!done) $display("FAIL timeout: got no frame_done expected at cycle %0d", done_c);
    else pass_cnt++;
    total_cnt++;
    if (sb.size() != 0 || sent != npix)
      $display("FAIL pixel_count: got sent %0d pending %0d expected %0d/0", sent, sb.size(), npix);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL after_done: got done %b busy %b expected 0 0", frame_done, busy);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; wr_ready = 1'b1;
    cfg_basic();
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({wr_valid, busy, frame_done, in_ready} !== 4'b0 || wr_addr !== '0 || wr_data !== '0)
      $display("FAIL reset: got v%b b%b d%b r%b a%h w%h expected all 0",
               wr_valid, busy, frame_done, in_ready, wr_addr, wr_data);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    cfg_basic();
    do_start();
    run_frame(8, -1, -1, 9, -1);
  endtask

  task automatic test_backpressure();
    cfg_basic();
    do_start();
    run_frame(8, 3, 5, 12, -1);
  endtask

  task automatic test_zero_frame();
    set_cfg(16'd0, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd10, 16'd20,
            16'd0, 16'd100, 16'd200, 16'd300);
    do_start();
    in_valid = 1'b1;
    #1;
    total_cnt++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || wr_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL zero_done: got d%b b%b v%b r%b expected 1 0 0 0", frame_done, busy, wr_valid, in_ready);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || wr_valid !== 1'b0)
      $display("FAIL zero_after: got d%b b%b v%b expected 0 0 0", frame_done, busy, wr_valid);
    else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    cfg_basic();
    do_start();
    in_valid = 1'b1; in_data = 16'h5555; wr_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (wr_valid !== 1'b1) $display("FAIL mid_pending: got %b expected 1", wr_valid);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== '0)
      $display("FAIL mid_reset: got v%b b%b a%h expected 0 0 0000", wr_valid, busy, wr_addr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; wr_ready = 1'b1;
    do_start();
    run_frame(8, -1, -1, 9, -1);
  endtask

  task automatic test_wrap_and_start_ignored();
    set_cfg(16'd4, 16'd1, 16'd8, 16'd8, 16'hFFFF, 16'd0, 16'd0, 16'd0,
            16'd5, 16'd0, 16'd0, 16'd0);
    exp_addr[0] = 16'd5; exp_addr[1] = 16'd4; exp_addr[2] = 16'd3; exp_addr[3] = 16'h0002;
    do_start();
    run_frame(4, -1, -1, 5, 2);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_frame();
    test_reset_mid_frame();
    test_wrap_and_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
